// File: rtl/branch_cond_stage.sv
// Registered branch-condition stage: turns comparator flags plus a condition code into a
// taken/not-taken decision behind a one-entry valid/ready pipe register.
module branch_cond_stage #(
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       cmp_flags,
   input  logic [2:0]       cond,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_taken,
   output logic [TAG_W-1:0] out_tag,
   output logic [2:0]       flags_q,
   output logic             err_flags,
   input  logic             clr,
   output logic [CNT_W-1:0] taken_cnt
);

   typedef enum logic [2:0] {
      COND_EQ = 3'b000,
      COND_NE = 3'b001,
      COND_LT = 3'b010,
      COND_GE = 3'b011,
      COND_GT = 3'b100,
      COND_LE = 3'b101,
      COND_AL = 3'b110,
      COND_NV = 3'b111
   } cond_e;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } pipe_state_e;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   pipe_state_e      state_q, state_d;
   logic             taken_q, taken_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [2:0]       last_flags_q, last_flags_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic accept;
   logic flags_legal;
   logic cond_hit;
   logic gt, lt, eq;

   assign gt = cmp_flags[0];
   assign lt = cmp_flags[1];
   assign eq = cmp_flags[2];

   // Exactly one of gt/lt/eq may be set; anything else means the comparator misbehaved.
   assign flags_legal = (cmp_flags == 3'b001) || (cmp_flags == 3'b010) || (cmp_flags == 3'b100);

   assign out_valid = (state_q == FULL);
   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;

   assign out_taken = taken_q;
   assign out_tag   = tag_q;
   assign flags_q   = last_flags_q;
   assign err_flags = err_q;
   assign taken_cnt = cnt_q;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      cond_hit = 1'b0;
      case (cond_e'(cond))
         COND_EQ: cond_hit = eq;
         COND_NE: cond_hit = !eq;
         COND_LT: cond_hit = lt;
         COND_GE: cond_hit = gt || eq;
         COND_GT: cond_hit = gt;
         COND_LE: cond_hit = lt || eq;
         COND_AL: cond_hit = 1'b1;
         COND_NV: cond_hit = 1'b0;
         default: cond_hit = 1'b0;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      taken_d      = taken_q;
      tag_d        = tag_q;
      last_flags_d = last_flags_q;
      err_d        = err_q;
      cnt_d        = cnt_q;

      case (state_q)
         EMPTY: if (accept) state_d = FULL;
         FULL:  if (out_ready && !accept) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase

      if (accept) begin
         // Illegal flags still flow through so the consumer sees the tag, but never as taken.
         taken_d = flags_legal && cond_hit;
         tag_d   = in_tag;
         if (flags_legal) begin
            last_flags_d = cmp_flags;
         end else begin
            err_d = 1'b1;
         end
         if (taken_d && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      if (clr) begin
         cnt_d = '0;
         err_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         state_q      <= EMPTY;
         taken_q      <= 1'b0;
         tag_q        <= '0;
         last_flags_q <= 3'b000;
         err_q        <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         taken_q      <= taken_d;
         tag_q        <= tag_d;
         last_flags_q <= last_flags_d;
         err_q        <= err_d;
         cnt_q        <= cnt_d;
      end
   end

endmodule

// File: tb/tb_branch_cond_stage.sv
// Directed bench for branch_cond_stage; a second instance with CNT_W=2 covers counter saturation.
module tb_branch_cond_stage;

   logic       clk = 1'b0;
   logic       rst, in_valid, out_ready, clr;
   logic [2:0] cmp_flags, cond;
   logic [3:0] in_tag;

   logic        in_ready, out_valid, out_taken, err_flags;
   logic [3:0]  out_tag;
   logic [2:0]  flags_q;
   logic [15:0] taken_cnt;

   logic        in_ready2, out_valid2, out_taken2, err_flags2;
   logic [3:0]  out_tag2;
   logic [2:0]  flags_q2;
   logic [1:0]  taken_cnt2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   branch_cond_stage #(.TAG_W(4), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .cmp_flags(cmp_flags), .cond(cond), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
      .out_tag(out_tag), .flags_q(flags_q), .err_flags(err_flags),
      .clr(clr), .taken_cnt(taken_cnt)
   );

   branch_cond_stage #(.TAG_W(4), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
      .cmp_flags(cmp_flags), .cond(cond), .in_tag(in_tag),
      .out_valid(out_valid2), .out_ready(out_ready), .out_taken(out_taken2),
      .out_tag(out_tag2), .flags_q(flags_q2), .err_flags(err_flags2),
      .clr(clr), .taken_cnt(taken_cnt2)
   );

   // Snapshot of the main instance: {in_ready, out_valid, out_taken, out_tag, flags_q, err, cnt}
   function automatic logic [26:0] snap();
      return {in_ready, out_valid, out_taken, out_tag, flags_q, err_flags, taken_cnt};
   endfunction

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] f, input logic [2:0] c, input logic [3:0] t);
      in_valid  = v;
      cmp_flags = f;
      cond      = c;
      in_tag    = t;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      out_ready = 1'b1;
      clr = 1'b0;
      drive(1'b0, 3'b000, 3'b000, 4'd0);
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [26:0] exp;
      rst = 1'b1;
      out_ready = 1'b0;
      clr = 1'b0;
      drive(1'b1, 3'b100, 3'b110, 4'd9);
      step();
      rst = 1'b0;
      drive(1'b0, 3'b000, 3'b000, 4'd0);
      out_ready = 1'b1;
      exp = {1'b1, 1'b0, 1'b0, 4'd0, 3'b000, 1'b0, 16'd0};
      total++;
      if (snap() !== exp) begin
         bad++;
         $display("FAIL reset_state: got %h expected %h", snap(), exp);
      end
   endtask

   task automatic test_basic();
      logic [26:0] exp;
      do_reset();
      drive(1'b1, 3'b100, 3'b000, 4'd3);
      step();
      drive(1'b0, 3'b000, 3'b000, 4'd0);
      exp = {1'b1, 1'b1, 1'b1, 4'd3, 3'b100, 1'b0, 16'd1};
      total++;
      if (snap() !== exp) begin
         bad++;
         $display("FAIL basic_eq: got %h expected %h", snap(), exp);
      end
      step();
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL basic_drain: out_valid got %b expected 0", out_valid);
      end
   endtask

   task automatic test_cond_sweep();
      logic [7:0] exp_pat;
      exp_pat = 8'b0110_0110;
      do_reset();
      for (int c = 0; c < 8; c++) begin
         drive(1'b1, 3'b010, 3'(c), 4'(c));
         step();
         total++;
         if ({out_valid, out_taken, out_tag} !== {1'b1, exp_pat[c], 4'(c)}) begin
            bad++;
            $display("FAIL cond_sweep_%0d: got v/t/tag %b/%b/%0d expected 1/%b/%0d",
                     c, out_valid, out_taken, out_tag, exp_pat[c], c);
         end
      end
      drive(1'b0, 3'b000, 3'b000, 4'd0);
      total++;
      if ({taken_cnt, flags_q} !== {16'd4, 3'b010}) begin
         bad++;
         $display("FAIL cond_sweep_cnt: got cnt=%0d flags=%b expected cnt=4 flags=010",
                  taken_cnt, flags_q);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      drive(1'b1, 3'b001, 3'b100, 4'd5);
      step();
      out_ready = 1'b0;
      drive(1'b1, 3'b100, 3'b001, 4'd6);
      #1;
      total++;
      if (in_ready !== 1'b0) begin
         bad++;
         $display("FAIL stall_ready: in_ready got %b expected 0", in_ready);
      end
      for (int i = 0; i < 5; i++) begin
         step();
         total++;
         if ({in_ready, out_valid, out_taken, out_tag} !== {1'b0, 1'b1, 1'b1, 4'd5}) begin
            bad++;
            $display("FAIL stall_hold_%0d: got r/v/t/tag %b/%b/%b/%0d expected 0/1/1/5",
                     i, in_ready, out_valid, out_taken, out_tag);
         end
      end
      out_ready = 1'b1;
      step();
      total++;
      if ({out_valid, out_taken, out_tag} !== {1'b1, 1'b0, 4'd6}) begin
         bad++;
         $display("FAIL release: got v/t/tag %b/%b/%0d expected 1/0/6", out_valid, out_taken, out_tag);
      end
      for (int t = 7; t <= 9; t++) begin
         drive(1'b1, 3'b100, 3'b000, 4'(t));
         step();
         total++;
         if ({in_ready, out_valid, out_taken, out_tag} !== {1'b1, 1'b1, 1'b1, 4'(t)}) begin
            bad++;
            $display("FAIL stream_%0d: got r/v/t/tag %b/%b/%b/%0d expected 1/1/1/%0d",
                     t, in_ready, out_valid, out_taken, out_tag, t);
         end
      end
      drive(1'b0, 3'b000, 3'b000, 4'd0);
      step();
      total++;
      if ({out_valid, taken_cnt} !== {1'b0, 16'd4}) begin
         bad++;
         $display("FAIL stream_end: got v=%b cnt=%0d expected v=0 cnt=4", out_valid, taken_cnt);
      end
   endtask

   task automatic test_illegal();
      logic [26:0] exp;
      do_reset();
      drive(1'b1, 3'b001, 3'b110, 4'd1);
      step();
      drive(1'b1, 3'b011, 3'b110, 4'd2);
      step();
      exp = {1'b1, 1'b1, 1'b0, 4'd2, 3'b001, 1'b1, 16'd1};
      total++;
      if (snap() !== exp) begin
         bad++;
         $display("FAIL illegal_011: got %h expected %h", snap(), exp);
      end
      drive(1'b1, 3'b000, 3'b110, 4'd3);
      step();
      exp = {1'b1, 1'b1, 1'b0, 4'd3, 3'b001, 1'b1, 16'd1};
      total++;
      if (snap() !== exp) begin
         bad++;
         $display("FAIL illegal_000: got %h expected %h", snap(), exp);
      end
      drive(1'b0, 3'b000, 3'b000, 4'd0);
      clr = 1'b1;
      step();
      total++;
      if ({err_flags, taken_cnt} !== {1'b0, 16'd0}) begin
         bad++;
         $display("FAIL clr_err: got err=%b cnt=%0d expected err=0 cnt=0", err_flags, taken_cnt);
      end
      drive(1'b1, 3'b111, 3'b110, 4'd4);
      step();
      clr = 1'b0;
      drive(1'b0, 3'b000, 3'b000, 4'd0);
      total++;
      if ({err_flags, out_tag, flags_q} !== {1'b0, 4'd4, 3'b001}) begin
         bad++;
         $display("FAIL clr_beats_err: got err=%b tag=%0d flags=%b expected err=0 tag=4 flags=001",
                  err_flags, out_tag, flags_q);
      end
   endtask

   task automatic test_saturate();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 3'b100, 3'b000, 4'(i));
         step();
      end
      total++;
      if ({taken_cnt2, out_taken2, taken_cnt} !== {2'd3, 1'b1, 16'd5}) begin
         bad++;
         $display("FAIL saturate: got cnt2=%0d taken2=%b cnt=%0d expected cnt2=3 taken2=1 cnt=5",
                  taken_cnt2, out_taken2, taken_cnt);
      end
      clr = 1'b1;
      step();
      clr = 1'b0;
      drive(1'b0, 3'b000, 3'b000, 4'd0);
      total++;
      if ({taken_cnt2, out_valid2, out_taken2, taken_cnt} !== {2'd0, 1'b1, 1'b1, 16'd0}) begin
         bad++;
         $display("FAIL clr_beats_inc: got cnt2=%0d v2=%b t2=%b cnt=%0d expected 0/1/1/0",
                  taken_cnt2, out_valid2, out_taken2, taken_cnt);
      end
   endtask

   task automatic test_rst_mid();
      logic [26:0] exp;
      do_reset();
      drive(1'b1, 3'b010, 3'b010, 4'd7);
      step();
      drive(1'b1, 3'b010, 3'b101, 4'd8);
      step();
      out_ready = 1'b0;
      total++;
      if ({out_valid, taken_cnt} !== {1'b1, 16'd2}) begin
         bad++;
         $display("FAIL rst_mid_setup: got v=%b cnt=%0d expected v=1 cnt=2", out_valid, taken_cnt);
      end
      rst = 1'b1;
      drive(1'b1, 3'b011, 3'b110, 4'd9);
      clr = 1'b0;
      step();
      rst = 1'b0;
      drive(1'b0, 3'b000, 3'b000, 4'd0);
      exp = {1'b1, 1'b0, 1'b0, 4'd0, 3'b000, 1'b0, 16'd0};
      total++;
      if (snap() !== exp) begin
         bad++;
         $display("FAIL rst_mid: got %h expected %h", snap(), exp);
      end
      out_ready = 1'b1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_cond_sweep();
      test_back_to_back();
      test_illegal();
      test_saturate();
      test_rst_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
